// File: rtl/mem_port_arbiter.sv
// Arbiter for the CPU's unified memory port: data requests win by default,
// and a saturating streak counter bounds how long a pending fetch can be starved.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [1:0]        owner_o,
  output logic              stall_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_FETCH  = 2'b01;
  localparam logic [1:0] OWN_DATA   = 2'b10;

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic [1:0]        own_q, own_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_data_s;
  logic              grant_fetch_s;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      streak_q    <= 4'd0;
      own_q       <= OWN_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      own_q       <= own_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state, arbitration and capture logic
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    own_d         = own_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    // Fetch overrides data only once the streak has reached its bound
    grant_data_s  = d_req_i & ~(i_req_i & (streak_q == STREAK_MAX));
    grant_fetch_s = i_req_i & ~grant_data_s;
    case (state_q)
      ST_IDLE: begin
        if (grant_data_s) begin
          state_d     = ST_D_BUSY;
          own_d       = OWN_DATA;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          if (!i_req_i) begin
            streak_d = 4'd0;
          end else if (streak_q == STREAK_MAX) begin
            streak_d = STREAK_MAX;
          end else begin
            streak_d = streak_q + 4'd1;
          end
        end else if (grant_fetch_s) begin
          state_d    = ST_I_BUSY;
          own_d      = OWN_FETCH;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr_i;
          streak_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_I_BUSY: begin
        if (mem_ready_i) begin
          i_rdata_d = mem_rdata_i;
          state_d   = ST_ACK;
        end else begin
          state_d = ST_I_BUSY;
        end
      end
      ST_D_BUSY: begin
        if (mem_ready_i) begin
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end else begin
            d_rdata_d = d_rdata_q;
          end
          state_d = ST_ACK;
        end else begin
          state_d = ST_D_BUSY;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    mem_req_o = 1'b0;
    i_ack_o   = 1'b0;
    d_ack_o   = 1'b0;
    owner_o   = OWN_NONE;
    case (state_q)
      ST_I_BUSY: begin
        mem_req_o = 1'b1;
        owner_o   = OWN_FETCH;
      end
      ST_D_BUSY: begin
        mem_req_o = 1'b1;
        owner_o   = OWN_DATA;
      end
      ST_ACK: begin
        owner_o = own_q;
        i_ack_o = (own_q == OWN_FETCH);
        d_ack_o = (own_q == OWN_DATA);
      end
      ST_IDLE: owner_o = OWN_NONE;
      default: owner_o = OWN_NONE;
    endcase
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign stall_o     = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model
// with random requesters, random memory latency and a mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int N_CYC      = 3000;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic [DATA_W-1:0] i_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_ack_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;
  logic [1:0]        owner_o;
  logic              stall_o;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .owner_o(owner_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the one transaction in flight plus the visible registers
  bit              m_valid, m_done, m_fetch, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_i_rdata, m_d_rdata;
  int              m_streak;
  bit              prev_i_ack, prev_d_ack;
  int              n_starve_fetch;

  task automatic model_reset();
    m_valid = 0; m_done = 0; m_fetch = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_i_rdata = '0; m_d_rdata = '0;
    m_streak = 0; prev_i_ack = 0; prev_d_ack = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
    check_val({tag, "_mem_we"}, 64'(mem_we_o), 64'd0);
    check_val({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    check_val({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'd0);
    check_val({tag, "_i_ack"}, 64'(i_ack_o), 64'd0);
    check_val({tag, "_d_ack"}, 64'(d_ack_o), 64'd0);
    check_val({tag, "_i_rdata"}, 64'(i_rdata_o), 64'd0);
    check_val({tag, "_d_rdata"}, 64'(d_rdata_o), 64'd0);
    check_val({tag, "_owner"}, 64'(owner_o), 64'd0);
  endtask

  initial begin
    bit exp_mem_req, exp_i_ack, exp_d_ack, exp_stall, data_wins, did_rst;
    logic [1:0] exp_owner;
    int p_i, p_d, p_rdy;

    rst_i = 1'b0; i_req_i = 1'b0; i_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; mem_ready_i = 1'b0;
    model_reset();
    n_starve_fetch = 0;
    did_rst = 0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("por");
    rst_i = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk_i);
      case ((cyc / 500) % 3)
        0:       begin p_i = 30; p_d = 30; p_rdy = 60; end
        1:       begin p_i = 95; p_d = 97; p_rdy = 80; end
        default: begin p_i = 50; p_d = 50; p_rdy = 15; end
      endcase

      // Requesters: hold until ack, then drop or re-request next cycle
      if (i_req_i && prev_i_ack) i_req_i = 1'b0;
      if (d_req_i && prev_d_ack) d_req_i = 1'b0;
      if (!i_req_i && ($urandom_range(99) < p_i)) begin
        i_req_i = 1'b1; i_addr_i = $urandom;
      end
      if (!d_req_i && ($urandom_range(99) < p_d)) begin
        d_req_i = 1'b1; d_we_i = 1'($urandom_range(1)); d_addr_i = $urandom; d_wdata_i = $urandom;
      end
      mem_ready_i = ($urandom_range(99) < p_rdy);
      mem_rdata_i = $urandom;

      // Asynchronous reset once, in the middle of a data access
      if (!did_rst && cyc > 700 && m_valid && !m_fetch && !m_done) begin
        did_rst = 1;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        i_req_i = 1'b0; d_req_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("midrst_hold");
        rst_i = 1'b1;
        continue;
      end
      #1;

      exp_mem_req = m_valid && !m_done;
      exp_i_ack   = m_valid && m_done && m_fetch;
      exp_d_ack   = m_valid && m_done && !m_fetch;
      exp_owner   = !m_valid ? 2'b00 : (m_fetch ? 2'b01 : 2'b10);
      exp_stall   = (i_req_i && !exp_i_ack) || (d_req_i && !exp_d_ack);
      check_val("mem_req", 64'(mem_req_o), 64'(exp_mem_req));
      check_val("i_ack", 64'(i_ack_o), 64'(exp_i_ack));
      check_val("d_ack", 64'(d_ack_o), 64'(exp_d_ack));
      check_val("owner", 64'(owner_o), 64'(exp_owner));
      check_val("stall", 64'(stall_o), 64'(exp_stall));
      check_val("mem_we", 64'(mem_we_o), 64'(m_we));
      check_val("mem_addr", 64'(mem_addr_o), 64'(m_addr));
      check_val("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
      check_val("i_rdata", 64'(i_rdata_o), 64'(m_i_rdata));
      check_val("d_rdata", 64'(d_rdata_o), 64'(m_d_rdata));
      prev_i_ack = exp_i_ack;
      prev_d_ack = exp_d_ack;

      // Advance the model over the coming rising edge
      if (m_valid && m_done) begin
        m_valid = 0;
      end else if (m_valid) begin
        if (mem_ready_i) begin
          m_done = 1;
          if (m_fetch) m_i_rdata = mem_rdata_i;
          else if (!m_we) m_d_rdata = mem_rdata_i;
        end
      end else begin
        data_wins = d_req_i && !(i_req_i && (m_streak == STARVE_MAX));
        if (data_wins) begin
          m_valid = 1; m_done = 0; m_fetch = 0;
          m_we = d_we_i; m_addr = d_addr_i; m_wdata = d_wdata_i;
          m_streak = i_req_i ? ((m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX) : 0;
        end else if (i_req_i) begin
          if (d_req_i) n_starve_fetch++;
          m_valid = 1; m_done = 0; m_fetch = 1;
          m_we = 1'b0; m_addr = i_addr_i;
          m_streak = 0;
        end
      end
    end

    $display("info: fetch grants won over a pending data request: %0d", n_starve_fetch);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's single unified memory port between the instruction-fetch requester (PC/fetch side) and the data requester (load/store side). Each requester uses a req/ack handshake. The block owns the memory-side request registers and drives a stall signal that freezes the PC and pipeline while an access is outstanding. Data accesses win by default, and a streak counter bounds how long instruction fetch can be starved.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants made while a fetch is pending; range 1..15
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- i_req_i  in  1  fetch request; held until i_ack_o
- i_addr_i  in  ADDR_W  fetch address; stable while i_req_i
- i_ack_o  out  1  one-cycle fetch completion pulse
- i_rdata_o  out  DATA_W  fetched word; valid when i_ack_o, held until next fetch ack
- d_req_i  in  1  data request; held until d_ack_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  load data; valid when d_ack_o (loads only), held otherwise
- mem_req_o  out  1  memory access active
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address (registered)
- mem_wdata_o  out  DATA_W  memory write data (registered)
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ready_i
- mem_ready_i  in  1  memory completes the current access this cycle
- owner_o  out  2  current owner: 00 none, 01 fetch, 10 data
- stall_o  out  1  combinational: (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o)

## Operation
- The FSM has four states: IDLE, I_BUSY, D_BUSY, ACK.
- IDLE, no request: remain in IDLE.
- IDLE, only d_req_i: grant data and go to D_BUSY.
- IDLE, only i_req_i: grant fetch and go to I_BUSY.
- IDLE, both requests: grant data unless streak == STARVE_MAX; in that case grant fetch.
- On grant, register the address, write data and write enable into the mem_* registers. For a fetch, mem_we_o = 0 and mem_wdata_o keeps its previous value.
- I_BUSY/D_BUSY: mem_req_o = 1. Wait for mem_ready_i.
- I_BUSY/D_BUSY with mem_ready_i: capture mem_rdata_i into the owner's rdata register (loads and fetches only), then go to ACK.
- ACK: mem_req_o = 0. Pulse the owner's ack for this cycle only. Next state is always IDLE.
- Requests present during ACK are ignored. A requester drops or changes its request in the cycle after it sees ack.
- Streak counter (4 bits):
  - data grant while i_req_i = 1: increment, saturating at STARVE_MAX
  - data grant while i_req_i = 0: clear
  - fetch grant: clear
- Request inputs sampled outside IDLE do not affect arbitration.
- A requester dropping req before its ack is a protocol violation; the transaction still completes and acks.
- owner_o: 01 in I_BUSY, 10 in D_BUSY, and the last owner during ACK; 00 in IDLE.

## Timing
- Reset values, asserted asynchronously:
  - state = IDLE, streak = 0
  - mem_req_o = mem_we_o = 0, mem_addr_o = mem_wdata_o = 0
  - i_ack_o = d_ack_o = 0, i_rdata_o = d_rdata_o = 0, owner_o = 00
- Reset during BUSY abandons the access. The memory model is reset by the same rst_i.
- Latency from the cycle a request is seen in IDLE (cycle 0):
  - mem_req_o high from cycle 1
  - if mem_ready_i arrives in cycle 1+k (k ≥ 0), ack is in cycle 2+k
  - IDLE again in cycle 3+k
- Minimum 3 cycles per access; a back-to-back request is re-sampled in the IDLE cycle.
- mem_addr_o, mem_we_o and mem_wdata_o are constant for the whole BUSY interval.
- A data and a fetch request asserted in the same cycle: data completes first, and the fetch is granted in the next IDLE.

## Test plan
- Fetch only, addr 0x0000_0010, memory returns 0xDEAD_BEEF with mem_ready_i in the first BUSY cycle -> mem_req_o in cycle 1, i_ack_o pulse in cycle 2 with i_rdata_o = 0xDEAD_BEEF, IDLE in cycle 3, stall_o high cycles 0–1.
- Load and fetch asserted simultaneously -> data granted first (owner_o = 10), d_ack_o, then fetch granted (owner_o = 01), i_ack_o. No overlap of mem_req_o between the two.
- Store d_we_i = 1, addr 0x40, wdata 0x1234_5678, mem_ready_i delayed 5 cycles -> mem_we_o/mem_addr_o/mem_wdata_o stable for all 6 BUSY cycles, d_ack_o in cycle 7, d_rdata_o unchanged.
- Starvation, STARVE_MAX = 4: d_req_i re-asserted every IDLE while i_req_i is held -> exactly 4 data grants, then a fetch grant, then streak = 0.
- rst_i low mid-D_BUSY -> all outputs at reset values immediately. After release, a new fetch completes normally in 3 cycles.
- Ack-cycle re-request: requester keeps d_req_i high during ACK and drops it one cycle later -> no second grant; FSM stays in IDLE.
